// File: rtl/zuart_rx.sv
// zuart_rx -- UART receiver, 8N1, fixed baud set by Freq_divider (clocks per bit).
//
// Ports:
//   iClk       single clock, all state changes on its rising edge
//   iRst_N     asynchronous active-low reset
//   iEn        receive enable; low forces IDLE on the next edge
//   iRxD       serial line: idle high, start low, 8 data bits LSB first, stop high
//   oData      last correctly framed byte
//   oValid     one-cycle pulse when oData updates
//   oFrameErr  one-cycle pulse when the stop bit samples low
//   oBusy      high whenever the receiver is not IDLE
//   oState     current FSM state (debug visibility)
//
// Handshake: oValid and oFrameErr are single-cycle strobes with no ready;
// a consumer must capture oData in the cycle oValid is high.
module zuart_rx #(
  parameter int Freq_divider = 50
) (
  input  logic       iClk,
  input  logic       iRst_N,
  input  logic       iEn,
  input  logic       iRxD,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrameErr,
  output logic       oBusy,
  output logic [2:0] oState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Full-width compare values: end of a whole bit, and end of half a bit.
  localparam logic [15:0] cFullM1 = 16'(Freq_divider - 1);
  localparam logic [15:0] cHalfM1 = 16'((Freq_divider / 2) - 1);

  state_t      state;
  logic [15:0] bitCnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;
  logic        rxMeta;
  logic        rxS;

  // Two-flop synchronizer; resets to the idle line level so that reset
  // release never looks like a start bit.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= iRxD;
      rxS    <= rxMeta;
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      state     <= IDLE;
      bitCnt    <= 16'd0;
      bitIdx    <= 3'd0;
      shiftReg  <= 8'h00;
      oData     <= 8'h00;
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      // Strobes default low so each can only last one cycle.
      oValid    <= 1'b0;
      oFrameErr <= 1'b0;
      if (!iEn) begin
        state  <= IDLE;
        bitCnt <= 16'd0;
        bitIdx <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            bitCnt <= 16'd0;
            if (!rxS) state <= START;
          end
          START: begin
            // Re-check the line half a bit in, rejecting short glitches.
            if (bitCnt == cHalfM1) begin
              bitCnt <= 16'd0;
              if (!rxS) begin
                state  <= DATA;
                bitIdx <= 3'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              bitCnt <= bitCnt + 16'd1;
            end
          end
          DATA: begin
            // Counter restarted at mid-start, so each sample lands mid-bit.
            if (bitCnt == cFullM1) begin
              bitCnt           <= 16'd0;
              shiftReg[bitIdx] <= rxS;
              if (bitIdx == 3'd7) state <= STOP;
              else                bitIdx <= bitIdx + 3'd1;
            end else begin
              bitCnt <= bitCnt + 16'd1;
            end
          end
          STOP: begin
            if (bitCnt == cFullM1) begin
              bitCnt <= 16'd0;
              if (rxS) begin
                oData  <= shiftReg;
                oValid <= 1'b1;
                state  <= IDLE;
              end else begin
                oFrameErr <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              bitCnt <= bitCnt + 16'd1;
            end
          end
          BREAK: begin
            // Wait out a held-low line so it reports only one framing error.
            bitCnt <= 16'd0;
            if (rxS) state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            bitCnt <= 16'd0;
            bitIdx <= 3'd0;
          end
        endcase
      end
    end
  end

  assign oBusy  = (state != IDLE);
  assign oState = state;

endmodule

// File: tb/tb_zuart_rx.sv
module tb_zuart_rx;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst_N;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // N=50 instance
  logic       en50, rxD50, valid50, err50, busy50;
  logic [7:0] data50;
  logic [2:0] state50;
  // N=4 instance
  logic       en4, rxD4, valid4, err4, busy4;
  logic [7:0] data4;
  logic [2:0] state4;

  zuart_rx #(.Freq_divider(50)) u50 (
    .iClk(iClk), .iRst_N(iRst_N), .iEn(en50), .iRxD(rxD50),
    .oData(data50), .oValid(valid50), .oFrameErr(err50), .oBusy(busy50),
    .oState(state50)
  );

  zuart_rx #(.Freq_divider(4)) u4 (
    .iClk(iClk), .iRst_N(iRst_N), .iEn(en4), .iRxD(rxD4),
    .oData(data4), .oValid(valid4), .oFrameErr(err4), .oBusy(busy4),
    .oState(state4)
  );

  // ---------------- scoreboard ----------------
  // Entry: {isFrameErr, oData at the pulse, cycle of the pulse}
  logic [40:0] expQ[$];
  logic [40:0] obsQ[$];
  logic [7:0]  lastGood = 8'h00;
  int nPass = 0;
  int nCheck = 0;
  int protoViol = 0;
  int busyRun = 0;
  int busyMax = 0;
  bit prevPulse = 1'b0;
  int valid4Cnt = 0;
  int err4Cnt = 0;
  int lastValid4Cyc = 0;

  always @(negedge iClk) begin
    if (valid50) obsQ.push_back({1'b0, data50, 32'(cyc)});
    if (err50)   obsQ.push_back({1'b1, data50, 32'(cyc)});
    if (valid50 && err50) protoViol++;
    if ((valid50 || err50) && prevPulse) protoViol++;
    prevPulse = valid50 || err50;
    if (busy50) busyRun++;
    else        busyRun = 0;
    if (busyRun > busyMax) busyMax = busyRun;
    if (valid4) begin
      valid4Cnt++;
      lastValid4Cyc = cyc;
    end
    if (err4) err4Cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCheck++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Compare everything observed against everything predicted, then flush.
  task automatic checkScore(input string tag);
    for (int t = 0; t < 3000 && obsQ.size() < expQ.size(); t++) @(posedge iClk);
    #1;
    check({tag, "_count"}, 64'(obsQ.size()), 64'(expQ.size()));
    while (obsQ.size() > 0 && expQ.size() > 0)
      check(tag, 64'(obsQ.pop_front()), 64'(expQ.pop_front()));
    obsQ.delete();
    expQ.delete();
  endtask

  // ---------------- driver tasks ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic driveBit(input int which, input logic v, input int cycles);
    if (which == 0) rxD50 = v;
    else            rxD4 = v;
    repeat (cycles) @(posedge iClk);
    #1;
  endtask

  // Reference model: outcome of a frame follows directly from the bit
  // timing (pulse at start + 3 + N/2 + 9N) and the stop-bit level.
  task automatic sendFrame(input int which, input logic [7:0] b, input bit stopGood);
    int n;
    int k;
    n = (which == 0) ? 50 : 4;
    k = cyc;
    if (which == 0) begin
      if (stopGood) begin
        expQ.push_back({1'b0, b, 32'(k + 3 + n / 2 + 9 * n)});
        lastGood = b;
      end else begin
        expQ.push_back({1'b1, lastGood, 32'(k + 3 + n / 2 + 9 * n)});
      end
    end
    driveBit(which, 1'b0, n);
    for (int i = 0; i < 8; i++) driveBit(which, b[i], n);
    driveBit(which, stopGood, n);
  endtask

  task automatic idle50(input int cycles);
    driveBit(0, 1'b1, cycles);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] rb;
    bit         rg;
    int         kk;
    iRst_N = 1'b0;
    en50 = 1'b1; en4 = 1'b1;
    rxD50 = 1'b1; rxD4 = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_data", 64'(data50), 64'h00);
    check("rst_valid", 64'(valid50), 64'h0);
    check("rst_ferr", 64'(err50), 64'h0);
    check("rst_busy", 64'(busy50), 64'h0);
    iRst_N = 1'b1;
    idle50(5);

    // Single good frame
    sendFrame(0, 8'hA5, 1'b1);
    check("a5_data", 64'(data50), 64'hA5);
    checkScore("a5");

    // Back-to-back frames, no idle gap
    sendFrame(0, 8'h00, 1'b1);
    sendFrame(0, 8'hFF, 1'b1);
    checkScore("b2b");
    check("b2b_data", 64'(data50), 64'hFF);
    idle50(10);

    // Short glitch: busy only for the half-bit verification window
    busyMax = 0;
    driveBit(0, 1'b0, 10);
    idle50(60);
    check("glitch_busymax", 64'(busyMax), 64'd25);
    check("glitch_busy", 64'(busy50), 64'h0);
    checkScore("glitch");

    // Bad stop bit, line held low, then recovery
    sendFrame(0, 8'h3C, 1'b0);
    driveBit(0, 1'b0, 2000);
    checkScore("break");
    check("break_data", 64'(data50), 64'(lastGood));
    idle50(10);
    sendFrame(0, 8'h81, 1'b1);
    checkScore("after_break");
    check("after_break_data", 64'(data50), 64'h81);
    idle50(10);

    // Reset asserted during data bit 4
    driveBit(0, 1'b0, 50);
    for (int i = 0; i < 4; i++) driveBit(0, i[0], 50);
    driveBit(0, 1'b1, 20);
    iRst_N = 1'b0;
    #2;
    check("midrst_data", 64'(data50), 64'h00);
    check("midrst_busy", 64'(busy50), 64'h0);
    check("midrst_valid", 64'(valid50), 64'h0);
    @(posedge iClk);
    #1;
    iRst_N = 1'b1;
    lastGood = 8'h00;
    idle50(60);
    checkScore("midrst");
    sendFrame(0, 8'h5A, 1'b1);
    checkScore("after_rst");
    check("after_rst_data", 64'(data50), 64'h5A);

    // Randomized frames with random gaps and occasional bad stop bits
    for (int f = 0; f < 6; f++) begin
      rb = 8'($urandom_range(0, 255));
      rg = ($urandom_range(0, 3) != 0);
      sendFrame(0, rb, rg);
      idle50(rg ? $urandom_range(0, 30) : $urandom_range(5, 30));
    end
    checkScore("random");
    check("random_data", 64'(data50), 64'(lastGood));

    // N=4: enable dropped mid DATA, then a clean frame
    driveBit(1, 1'b0, 4);
    for (int i = 0; i < 3; i++) driveBit(1, 1'b1, 4);
    en4 = 1'b0;
    @(posedge iClk);
    #1;
    check("en_busy", 64'(busy4), 64'h0);
    rxD4 = 1'b1;
    repeat (5) @(posedge iClk);
    #1;
    en4 = 1'b1;
    repeat (5) @(posedge iClk);
    #1;
    check("en_valid_cnt", 64'(valid4Cnt), 64'd0);
    check("en_data_kept", 64'(data4), 64'h00);
    kk = cyc;
    sendFrame(1, 8'hC3, 1'b1);
    driveBit(1, 1'b1, 10);
    check("n4_valid_cnt", 64'(valid4Cnt), 64'd1);
    check("n4_data", 64'(data4), 64'hC3);
    check("n4_latency", 64'(lastValid4Cyc), 64'(kk + 3 + 2 + 36));
    check("n4_ferr_cnt", 64'(err4Cnt), 64'd0);

    check("pulse_protocol", 64'(protoViol), 64'd0);
    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule

// File: doc/zuart_rx.md
ZUART_RX -- requirements
Module: zuart_rx

Interface
REQ-001 The block SHALL have parameter Freq_divider, default 50, meaning clocks per bit; legal range 4..65535.
REQ-002 The block SHALL have port iClk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port iRst_N, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port iEn, input, 1, receive enable; low SHALL force IDLE.
REQ-005 The block SHALL have port iRxD, input, 1, the serial line: idle high, 1 start (low), 8 data LSB first, 1 stop (high).
REQ-006 The block SHALL have port oData, output, 8, the last correctly framed byte.
REQ-007 The block SHALL have port oValid, output, 1, a one-cycle pulse when oData updates.
REQ-008 The block SHALL have port oFrameErr, output, 1, a one-cycle pulse when the stop bit samples low.
REQ-009 The block SHALL have port oBusy, output, 1, high whenever the state is not IDLE.

Function
REQ-010 iRxD SHALL pass through a 2-flop synchronizer (rx_s); both flops SHALL reset to 1, and only rx_s SHALL be used internally.
REQ-011 Let N=Freq_divider and H=floor(N/2); there SHALL be one 16-bit bit-timing counter, a 3-bit bit index and an 8-bit shift register.
REQ-012 The states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: with iEn=1 and rx_s=0 the block SHALL move to START with counter=0; otherwise it SHALL stay in IDLE with counter=0.
REQ-014 START: the counter SHALL increment each clock; at counter==H-1 the block SHALL sample rx_s. On 0 it SHALL go to DATA with counter=0 and index=0. On 1 (glitch) it SHALL return to IDLE with no pulse.
REQ-015 DATA: at counter==N-1 the block SHALL store rx_s into shift[index] and clear the counter, otherwise increment it. After index 7 it SHALL go to STOP, otherwise increment the index.
REQ-016 STOP: at counter==N-1 the block SHALL sample rx_s.
REQ-016a On 1: oData<=shift, oValid=1 for exactly one cycle, go to IDLE.
REQ-016b On 0: oFrameErr=1 for exactly one cycle, oData unchanged, go to BREAK.
REQ-017 BREAK: the block SHALL hold until rx_s==1, then go to IDLE; a line held low SHALL yield exactly one oFrameErr and no oValid.
REQ-018 Latency: if iRxD falls just after edge k, oValid (or oFrameErr) SHALL be high in the cycle following edge k+3+H+9N.
REQ-019 Data bit i SHALL be sampled at edge k+3+H+(i+1)N, i.e. near mid-bit.
REQ-020 A new start bit SHALL be accepted in the cycle immediately after returning to IDLE, with no dead time beyond that cycle.
REQ-021 oValid and oFrameErr SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-022 iEn=0 in any state SHALL give IDLE, counter=0 and index=0 on the next edge, with no pulse that cycle; oData SHALL be retained.
REQ-023 Counter compares SHALL use the full 16-bit width; the counter SHALL never wrap in normal operation.

Reset
REQ-024 While iRst_N=0 the outputs SHALL be oData=8'h00, oValid=0, oFrameErr=0, oBusy=0, with state=IDLE, counter=0, index=0, shift=0 and synchronizer=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no pulse; after release, the block SHALL wait for a new falling edge.

Verification
REQ-026 N=50, iEn=1, send 8'hA5 with a good stop bit: oData=8'hA5, a single oValid pulse exactly 478 clocks after the start edge, and oFrameErr never high.
REQ-027 N=50, back-to-back 8'h00 then 8'hFF with no idle gap: two oValid pulses 500 clocks apart, with oData=8'h00 then 8'hFF.
REQ-028 N=50, 10-clock low glitch on an idle line: no pulse, oBusy high for at most 28 clocks, then IDLE.
REQ-029 N=50, send 8'h3C with the stop bit low: a single oFrameErr pulse, oData keeps its previous value, no oValid; with the line held low 2000 clocks, no further pulse; after the line goes high, the next frame 8'h81 gives oValid with oData=8'h81.
REQ-030 N=50, iRst_N pulsed low during bit 4 of a frame: all outputs at reset values, no pulse; the next frame 8'h5A is received correctly.
REQ-031 N=4, iEn dropped during DATA then raised: IDLE with no pulse; the subsequent frame 8'hC3 gives oValid with oData=8'hC3.
